// File: rtl/microwave_pkg.sv
// ----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave front-panel controller.
//   BCD_MAX         largest keypad digit that is accepted
//   QUICK_SEC_TENS  tens-of-seconds digit loaded by the quick-start sequence
//   state_t         controller state encoding
// Optional feature macro: QUICK_START_EN adds the two quick-load states.
// ----------------------------------------------------------------------------
package microwave_pkg;

    localparam int STATE_W = 3;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam logic [3:0] QUICK_SEC_TENS = 4'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSED = 3'd3,
`ifdef QUICK_START_EN
        ST_DONE   = 3'd4,
        ST_QLOAD0 = 3'd5,
        ST_QLOAD1 = 3'd6
`else
        ST_DONE   = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to the once-per-second count pulse.
//   clock  in   system clock
//   reset  in   synchronous, active-high
//   run    in   advance the divider this cycle
//   clear  in   force the divider back to zero (wins over run)
//   tick   out  registered 1-cycle pulse, one cycle after the divider
//               reaches TICK_DIV-1 while running
// Parameter TICK_DIV: clock cycles per tick (>=2).
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // When run drops the count simply holds, which is what lets a paused
    // cook resume partway through the current second.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (run) begin
                if (count == LAST) begin
                    count <= '0;
                    tick  <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// ----------------------------------------------------------------------------
// microwave_ctrl
// Front-panel controller: keypad entry, start/stop/door handling, drives the
// external BCD countdown timer, magnetron enable and done beeper.
//   clock         in   system clock
//   reset         in   synchronous, active-high
//   keypad_valid  in   1-cycle strobe qualifying keypad_digit
//   keypad_digit  in   BCD digit (10..15 ignored)
//   start, stop   in   level inputs
//   door_closed   in   1 = door shut
//   timer_zero    in   countdown timer reads 0:00
//   timer_data    out  digit shifted into the timer
//   timer_loadn   out  active-low 1-cycle load strobe
//   timer_clrn    out  active-low clear
//   timer_en      out  1-cycle count pulse per second of cooking
//   mag_on        out  magnetron enable
//   done_beep     out  beeper
// Optional feature macro: QUICK_START_EN (start from IDLE cooks for 0:30).
// ----------------------------------------------------------------------------
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int MAX_DIGITS  = 3,
    parameter int BEEP_CYCLES = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] timer_data,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_en,
    output logic       mag_on,
    output logic       done_beep
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [DW-1:0] DIGIT_LIMIT = DW'(MAX_DIGITS);
    localparam logic [BW-1:0] BEEP_LAST   = BW'(BEEP_CYCLES - 1);

    state_t        state;
    logic [DW-1:0] digit_cnt;
    logic [BW-1:0] beep_cnt;
    logic          digit_ok;
    logic          cook_run;
    logic          prescale_clear;

    assign digit_ok = keypad_valid && (keypad_digit <= BCD_MAX) && (digit_cnt < DIGIT_LIMIT);

    // The divider only advances on cycles where cooking genuinely continues,
    // so a cycle that ends the cook (zero, stop, door) never emits a tick.
    assign cook_run = (state == ST_COOK) && !timer_zero && !stop && door_closed;

    // Outside COOK/PAUSED the divider sits at zero, giving every fresh cook
    // a full first second.
    assign prescale_clear = (state != ST_COOK) && (state != ST_PAUSED);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .run   (cook_run),
        .clear (prescale_clear),
        .tick  (timer_en)
    );

    // Main controller. Load and clear strobes default inactive every cycle so
    // each assignment below produces exactly a one-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            digit_cnt   <= '0;
            beep_cnt    <= '0;
            timer_data  <= 4'd0;
            timer_loadn <= 1'b1;
            timer_clrn  <= 1'b0;
            mag_on      <= 1'b0;
            done_beep   <= 1'b0;
        end else begin
            timer_loadn <= 1'b1;
            timer_clrn  <= 1'b1;
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (stop) begin
                        // Stop in IDLE has nothing to cancel but still masks the keypad.
                        if (state == ST_ENTRY) begin
                            timer_clrn <= 1'b0;
                            digit_cnt  <= '0;
                            state      <= ST_IDLE;
                        end
                    end else if (state == ST_ENTRY && start && door_closed) begin
                        state  <= ST_COOK;
                        mag_on <= 1'b1;
`ifdef QUICK_START_EN
                    end else if (state == ST_IDLE && start && door_closed) begin
                        timer_data  <= QUICK_SEC_TENS;
                        timer_loadn <= 1'b0;
                        state       <= ST_QLOAD0;
`endif
                    end else if (digit_ok) begin
                        timer_data  <= keypad_digit;
                        timer_loadn <= 1'b0;
                        digit_cnt   <= digit_cnt + DW'(1);
                        state       <= ST_ENTRY;
                    end
                end
`ifdef QUICK_START_EN
                ST_QLOAD0: begin
                    timer_data  <= 4'd0;
                    timer_loadn <= 1'b0;
                    state       <= ST_QLOAD1;
                end
                ST_QLOAD1: begin
                    // Door/stop seen during the loads are honoured here so the
                    // magnetron never fires with the door open.
                    if (door_closed && !stop) begin
                        state  <= ST_COOK;
                        mag_on <= 1'b1;
                    end else begin
                        state <= ST_PAUSED;
                    end
                end
`endif
                ST_COOK: begin
                    if (timer_zero) begin
                        state     <= ST_DONE;
                        mag_on    <= 1'b0;
                        done_beep <= 1'b1;
                        beep_cnt  <= '0;
                    end else if (stop || !door_closed) begin
                        state  <= ST_PAUSED;
                        mag_on <= 1'b0;
                    end else begin
                        mag_on <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (stop) begin
                        timer_clrn <= 1'b0;
                        digit_cnt  <= '0;
                        state      <= ST_IDLE;
                    end else if (start && door_closed) begin
                        state  <= ST_COOK;
                        mag_on <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (stop || beep_cnt == BEEP_LAST) begin
                        done_beep  <= 1'b0;
                        timer_clrn <= 1'b0;
                        digit_cnt  <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        beep_cnt <= beep_cnt + BW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mag_on <= 1'b0;
                end
            endcase
        end
    end

endmodule
